if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/mips_pkg.sv | 14 +
 rtl/if_id_reg.sv | 48 ++++
 rtl/if_stage.sv | 84 ++++++++
 tb/tb_if_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the fetch pipeline: data width, reset/bubble defaults
// and the sequential PC increment.
package mips_pkg;

   localparam int          WORD_W        = 32;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] PC_INC        = 32'h0000_0004;

   function automatic logic is_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit with hold and
// bubble controls. Bubble takes precedence over hold.
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic              bubble,
   input  logic [WORD_W-1:0] instr_in,
   input  logic [WORD_W-1:0] pcp4_in,
   output logic [WORD_W-1:0] instr,
   output logic [WORD_W-1:0] pcp4,
   output logic              valid
);

   logic [WORD_W-1:0] r_instr;
   logic [WORD_W-1:0] r_pcp4;
   logic              r_valid;

   // Pipeline register update: reset, bubble, hold, then load.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_instr <= NOP_INSTR;
         r_pcp4  <= {WORD_W{1'b0}};
         r_valid <= 1'b0;
      end else if (bubble) begin
         r_instr <= NOP_INSTR;
         r_pcp4  <= {WORD_W{1'b0}};
         r_valid <= 1'b0;
      end else if (hold) begin
         r_instr <= r_instr;
         r_pcp4  <= r_pcp4;
         r_valid <= r_valid;
      end else begin
         r_instr <= instr_in;
         r_pcp4  <= pcp4_in;
         r_valid <= 1'b1;
      end
   end

   assign instr = r_instr;
   assign pcp4  = r_pcp4;
   assign valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, misaligned-target trap, fetch counter
// and the IF/ID register. Next-PC selection is done outside this block.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [WORD_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] NextPC,
   input  logic              Stall,
   input  logic              Flush,
   input  logic [WORD_W-1:0] IData,
   output logic [WORD_W-1:0] PC,
   output logic [WORD_W-1:0] PCPlus4,
   output logic [WORD_W-1:0] ID_Instr,
   output logic [WORD_W-1:0] ID_PCPlus4,
   output logic              ID_Valid,
   output logic              AlignErr,
   output logic [WORD_W-1:0] FetchCnt
);

   logic [WORD_W-1:0] r_pc;
   logic              r_align_err;
   logic [WORD_W-1:0] r_fetch_cnt;

   logic [WORD_W-1:0] w_pc_plus4;
   logic              w_misalign;
   logic              w_pc_load;
   logic              w_err_set;
   logic              w_bubble;
   logic              w_fetch;

   assign w_pc_plus4 = r_pc + PC_INC;
   assign w_misalign = !is_aligned(NextPC[1:0]);
   // Once trapped the stage ignores Stall/Flush until reset.
   assign w_pc_load  = !r_align_err && (Flush || !Stall);
   assign w_err_set  = w_pc_load && w_misalign;
   assign w_bubble   = r_align_err || Flush || w_err_set;
   assign w_fetch    = w_pc_load && !Flush && !w_misalign;

   // PC register: a misaligned target leaves the PC where it was.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc <= RESET_PC;
      end else if (w_pc_load && !w_misalign) begin
         r_pc <= NextPC;
      end else begin
         r_pc <= r_pc;
      end
   end

   // Sticky alignment trap and count of real instructions entering IF/ID.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_align_err <= 1'b0;
         r_fetch_cnt <= {WORD_W{1'b0}};
      end else begin
         r_align_err <= r_align_err | w_err_set;
         r_fetch_cnt <= w_fetch ? (r_fetch_cnt + 32'd1) : r_fetch_cnt;
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk      (clk),
      .reset    (reset),
      .hold     (Stall),
      .bubble   (w_bubble),
      .instr_in (IData),
      .pcp4_in  (w_pc_plus4),
      .instr    (ID_Instr),
      .pcp4     (ID_PCPlus4),
      .valid    (ID_Valid)
   );

   assign PC       = r_pc;
   assign PCPlus4  = w_pc_plus4;
   assign AlignErr = r_align_err;
   assign FetchCnt = r_fetch_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Randomised bench for if_stage against a cycle-level reference model, plus
// directed scenarios with hand-computed expectations.
module tb_if_stage;

   logic        clk;
   logic        reset;
   logic [31:0] NextPC;
   logic        Stall;
   logic        Flush;
   logic [31:0] IData;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic [31:0] ID_Instr;
   logic [31:0] ID_PCPlus4;
   logic        ID_Valid;
   logic        AlignErr;
   logic [31:0] FetchCnt;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic        m_ok = 1'b0;
   logic [31:0] m_pc, m_instr, m_pcp4, m_cnt;
   logic        m_valid, m_err;

   localparam logic [31:0] NOP = 32'h0000_0000;
   localparam logic [31:0] IA  = 32'hAAAA_0001;
   localparam logic [31:0] IB  = 32'hBBBB_0002;
   localparam logic [31:0] IC  = 32'hCCCC_0003;
   localparam logic [31:0] ID  = 32'hDDDD_0004;

   if_stage dut (
      .clk        (clk),
      .reset      (reset),
      .NextPC     (NextPC),
      .Stall      (Stall),
      .Flush      (Flush),
      .IData      (IData),
      .PC         (PC),
      .PCPlus4    (PCPlus4),
      .ID_Instr   (ID_Instr),
      .ID_PCPlus4 (ID_PCPlus4),
      .ID_Valid   (ID_Valid),
      .AlignErr   (AlignErr),
      .FetchCnt   (FetchCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: what the fetch stage must hold after each rising edge.
   always @(posedge clk) begin
      if (reset) begin
         m_ok = 1'b1; m_pc = 32'h0; m_instr = NOP; m_pcp4 = 32'h0;
         m_valid = 1'b0; m_err = 1'b0; m_cnt = 32'h0;
      end else if (m_ok) begin
         if (m_err) begin
            m_instr = NOP; m_pcp4 = 32'h0; m_valid = 1'b0;
         end else if (Flush || !Stall) begin
            if (NextPC % 4 != 0) begin
               m_err = 1'b1; m_instr = NOP; m_pcp4 = 32'h0; m_valid = 1'b0;
            end else if (Flush) begin
               m_pc = NextPC; m_instr = NOP; m_pcp4 = 32'h0; m_valid = 1'b0;
            end else begin
               m_pcp4 = m_pc + 32'd4; m_instr = IData; m_valid = 1'b1;
               m_cnt = m_cnt + 32'd1; m_pc = NextPC;
            end
         end
      end
   end

   // Compare process: every output against the model, mid-cycle.
   always @(negedge clk) begin
      if (m_ok) begin
         chk("PC", PC, m_pc);
         chk("PCPlus4", PCPlus4, m_pc + 32'd4);
         chk("ID_Instr", ID_Instr, m_instr);
         chk("ID_PCPlus4", ID_PCPlus4, m_pcp4);
         chk("ID_Valid", {31'd0, ID_Valid}, {31'd0, m_valid});
         chk("AlignErr", {31'd0, AlignErr}, {31'd0, m_err});
         chk("FetchCnt", FetchCnt, m_cnt);
      end
   end

   task automatic cyc(input logic rst, input logic st, input logic fl,
                      input logic [31:0] npc, input logic [31:0] idata);
      reset = rst; Stall = st; Flush = fl; NextPC = npc; IData = idata;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] npc;
      logic [31:0] held_pc;
      reset = 1'b1; Stall = 1'b0; Flush = 1'b0; NextPC = 32'h0; IData = 32'h0;
      @(negedge clk);
      #1;

      // reset state
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("rst_pc", PC, 32'h0);
      chk("rst_valid", {31'd0, ID_Valid}, 32'd0);
      chk("rst_cnt", FetchCnt, 32'd0);
      chk("rst_pcp4", PCPlus4, 32'd4);

      // sequential fetch, then a two-cycle stall at PC=8
      cyc(1'b0, 1'b0, 1'b0, 32'd4, IA);
      chk("seq_instrA", ID_Instr, IA);
      chk("seq_idpcp4", ID_PCPlus4, 32'd4);
      cyc(1'b0, 1'b0, 1'b0, 32'd8, IB);
      chk("seq_pc8", PC, 32'd8);
      chk("seq_instrB", ID_Instr, IB);
      cyc(1'b0, 1'b1, 1'b0, 32'd12, IC);
      cyc(1'b0, 1'b1, 1'b0, 32'd12, IC);
      chk("stall_pc", PC, 32'd8);
      chk("stall_instr", ID_Instr, IB);
      chk("stall_cnt", FetchCnt, 32'd2);
      cyc(1'b0, 1'b0, 1'b0, 32'd12, IC);
      chk("resume_pc", PC, 32'd12);
      chk("resume_instr", ID_Instr, IC);
      chk("resume_cnt", FetchCnt, 32'd3);

      // flush wins over stall
      cyc(1'b0, 1'b1, 1'b1, 32'h40, ID);
      chk("flush_pc", PC, 32'h40);
      chk("flush_valid", {31'd0, ID_Valid}, 32'd0);
      chk("flush_instr", ID_Instr, NOP);
      chk("flush_cnt", FetchCnt, 32'd3);

      // PC wrap at the top of the address space
      cyc(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, ID);
      chk("wrap_pcp4", PCPlus4, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, IA);
      chk("wrap_pc", PC, 32'h0);
      chk("wrap_err", {31'd0, AlignErr}, 32'd0);
      chk("wrap_idpcp4", ID_PCPlus4, 32'h0);

      // reset while stalled with a valid instruction
      cyc(1'b0, 1'b0, 1'b0, 32'd4, IB);
      cyc(1'b0, 1'b1, 1'b0, 32'd8, IC);
      chk("pre_rst_valid", {31'd0, ID_Valid}, 32'd1);
      cyc(1'b1, 1'b1, 1'b0, 32'h42, IC);
      chk("stallrst_valid", {31'd0, ID_Valid}, 32'd0);
      chk("stallrst_cnt", FetchCnt, 32'd0);
      chk("stallrst_pc", PC, 32'h0);

      // misaligned target: sticky trap, cleared only by reset
      cyc(1'b0, 1'b0, 1'b0, 32'd4, IA);
      cyc(1'b0, 1'b0, 1'b0, 32'h42, IB);
      chk("mis_pc", PC, 32'd4);
      chk("mis_err", {31'd0, AlignErr}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'd8, IC);
         chk("mis_hold_pc", PC, 32'd4);
         chk("mis_hold_valid", {31'd0, ID_Valid}, 32'd0);
      end
      cyc(1'b1, 1'b0, 1'b1, 32'h42, IC);
      chk("mis_clr_err", {31'd0, AlignErr}, 32'd0);
      chk("mis_clr_pc", PC, 32'h0);

      // randomised traffic checked by the model
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 9))
            0:       npc = $urandom & 32'hFFFF_FFFC;
            1:       npc = (($urandom_range(0, 40) == 0) ? $urandom : m_pc + 32'd4);
            default: npc = m_pc + 32'd4;
         endcase
         held_pc = m_pc;
         cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0), npc, $urandom);
         if (m_err && !reset) chk("rnd_trap_pc", PC, held_pc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
